tap_delay_buffer: RTL and testbench
===================================

# tap_delay_buffer

Multi-channel, RAM-backed sample history for the FIR/effect datapath. Each accepted input frame (one sample per channel) is written into a circular buffer. The block then autonomously sweeps every tap of every channel, newest first, presenting one delayed sample per cycle to the downstream MAC. This replaces the shift-register-plus-external-counter scheme and adds channel count, input handshake, sweep sequencing and tap/channel tagging.

## Interface
- DATA_BITS, 16: signed sample width.
- CHANNELS, 2: channels per frame.
- NUMBER_OF_TAPS, 64: history depth per channel; power of two, ≥ 2.
- ADDR_BITS, 6: log2(NUMBER_OF_TAPS).
- CHAN_BITS, 1: max(1, clog2(CHANNELS)).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  frame present.
- in_ready  out  1  block can accept a frame.
- in_data  in  CHANNELS*DATA_BITS  frame; channel c at bits [c*DATA_BITS +: DATA_BITS], signed.
- out_valid  out  1  out_* beat valid.
- out_data  out  DATA_BITS  signed delayed sample.
- out_chan  out  CHAN_BITS  channel of beat.
- out_tap  out  ADDR_BITS  delay in frames (0 = newest).
- out_first  out  1  beat is chan 0, tap 0.
- out_last  out  1  beat is chan CHANNELS-1, tap NUMBER_OF_TAPS-1.

## Operation
- FSM states:
  - CLEAR: only with the Configuration macro. Writes zero to every address, 1 address/cycle.
  - IDLE: in_ready=1.
  - SWEEP: issues reads.
- IDLE→SWEEP on in_valid&&in_ready.
  - Accept cycle writes in_data at wr_ptr.
  - newest_ptr<=wr_ptr; wr_ptr<=wr_ptr+1 (natural wrap mod NUMBER_OF_TAPS).
- SWEEP order: channel-major; for chan 0..CHANNELS-1, tap 0..NUMBER_OF_TAPS-1.
  - Read address = newest_ptr − tap, mod 2^ADDR_BITS (wrap-around by truncation).
- SWEEP→IDLE after issuing (CHANNELS-1, NUMBER_OF_TAPS-1).
- out_chan/out_tap/out_first/out_last are pipelined alongside the read so they align with out_data.
- Taps older than the number of frames written since reset:
  - With CLEAR: return 0.
  - Without CLEAR: contents undefined.
- Data is passed bit-exact, with no arithmetic on samples. Full signed range is preserved (e.g. 16'h8000 stays 16'h8000).
- in_valid while in_ready=0 is legal. Upstream holds in_data until acceptance; no frame is ever dropped or overwritten.
- Upstream frame period must be ≥ CHANNELS*NUMBER_OF_TAPS+1 cycles for continuous rate. Slower rates simply idle.

## Timing
- Accept at cycle T:
  - Reads issued T+1 … T+C·N.
  - out_valid T+2 … T+C·N+1.
  - in_ready=1 again from T+C·N+1, so back-to-back frames are accepted at T+C·N+1. The final beat of the old sweep overlaps the new write harmlessly (different cycle for RAM read issue).
- Read latency: 1 cycle, registered RAM output. The write at T is visible to the read issued at T+1.
- out_valid has no backpressure; downstream consumes every beat.
- Reset values: in_ready=0 during rst.
  - Other outputs: out_valid=0, out_data=0, out_chan=0, out_tap=0, out_first=0, out_last=0.
  - wr_ptr=0, newest_ptr=0.
- First cycle after rst deasserts:
  - Without CLEAR: IDLE, in_ready=1.
  - With CLEAR: CLEAR for NUMBER_OF_TAPS cycles, in_ready=0; IDLE and in_ready=1 on cycle NUMBER_OF_TAPS.
- rst asserted mid-sweep: out_valid=0 the following cycle. The sweep is abandoned and the FSM re-enters CLEAR or IDLE; no partial beat follows.
- in_valid coincident with rst: ignored.

## Configuration
- TAP_DELAY_BUFFER_CLEAR_EN defined: CLEAR state compiled in. Memory is zeroed after every reset; unwritten taps read 0.
- Macro undefined: no CLEAR state; in_ready rises the cycle after reset. Unwritten taps are undefined, X in simulation, with smaller area/no reset-time stall.

## Structure
- Shared package/header:
  - FSM state encodings (ST_CLEAR, ST_IDLE, ST_SWEEP).
  - CHAN_BITS derivation.
  - Default DATA_BITS/NUMBER_OF_TAPS constants, shared with the FIR coefficient ROM and MAC.
- Sub-module tap_delay_ram:
  - Simple dual-port, depth NUMBER_OF_TAPS, width CHANNELS*DATA_BITS.
  - One synchronous write port, one registered read port; no reset on the array, to allow BSRAM inference.
- Top owns FSM, pointers, sweep counters, tag pipeline and the channel-select mux on the wide read word.

## Test plan
All with N=8, C=2, CLEAR_EN defined unless noted.
1. Release rst → in_ready=0 for 8 cycles, =1 on cycle 8; outputs all 0 throughout.
2. Push frame {ch1=16'h0200, ch0=16'h0100} at T → 16 beats T+2…T+17.
   - ch0 tap0=0x0100, ch1 tap0=0x0200, all other taps 0.
   - out_first at T+2, out_last at T+17.
3. Push ch0 values 1..10 (ch1=−v) → final sweep ch0 taps 0..7 = 10,9,…,3; ch1 = −10…−3 (pointer wrap).
4. Hold in_valid continuously → in_ready low for exactly 16 cycles per sweep; frames accepted every 17 cycles; no frame lost or duplicated.
5. Assert rst at 5th beat of a sweep → out_valid=0 next cycle; after CLEAR, push 0x0007 → tap0=7, taps 1..7=0.
6. Push 16'h8000/16'h7FFF → read back bit-exact. Repeat scenario 1 without CLEAR_EN → in_ready=1 one cycle after rst deasserts.

Source files
------------

// File: rtl/tap_delay_buffer_pkg.sv
// Shared constants and FSM encoding for the tap delay buffer and its FIR neighbours.
// The FIR coefficient ROM and MAC use the same default widths and depth.
package tap_delay_buffer_pkg;

    localparam int DEFAULT_DATA_BITS      = 16;
    localparam int DEFAULT_CHANNELS       = 2;
    localparam int DEFAULT_NUMBER_OF_TAPS = 64;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    // Keeps the channel tag at least one bit wide so single-channel builds stay legal.
    function automatic int chan_bits(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/tap_delay_ram.sv
// Simple dual-port sample history RAM: one synchronous write port, one registered read port.
// The array has no reset so it maps onto block RAM.
module tap_delay_ram #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 64,
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/tap_delay_buffer.sv
// Multi-channel RAM-backed sample history; each accepted frame triggers a newest-first tap sweep.
// Define TAP_DELAY_BUFFER_CLEAR_EN to zero the history after every reset.
module tap_delay_buffer
    import tap_delay_buffer_pkg::*;
#(
    parameter int DATA_BITS      = DEFAULT_DATA_BITS,
    parameter int CHANNELS       = DEFAULT_CHANNELS,
    parameter int NUMBER_OF_TAPS = DEFAULT_NUMBER_OF_TAPS,
    parameter int ADDR_BITS      = $clog2(NUMBER_OF_TAPS),
    parameter int CHAN_BITS      = chan_bits(CHANNELS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHANNELS*DATA_BITS-1:0] in_data,
    output logic                          out_valid,
    output logic [DATA_BITS-1:0]          out_data,
    output logic [CHAN_BITS-1:0]          out_chan,
    output logic [ADDR_BITS-1:0]          out_tap,
    output logic                          out_first,
    output logic                          out_last
);

    localparam int                   WORD_BITS = CHANNELS * DATA_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_TAP  = ADDR_BITS'(NUMBER_OF_TAPS - 1);
    localparam logic [CHAN_BITS-1:0] LAST_CHAN = CHAN_BITS'(CHANNELS - 1);
`ifdef TAP_DELAY_BUFFER_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t               state_reg, state_next;
    logic [ADDR_BITS-1:0] wr_ptr_reg, newest_ptr_reg, tap_reg;
    logic [CHAN_BITS-1:0] chan_reg;
`ifdef TAP_DELAY_BUFFER_CLEAR_EN
    logic [ADDR_BITS-1:0] clear_addr_reg;
`endif
    logic                 accept, issue, sweep_done;
    logic                 ram_wr_en;
    logic [ADDR_BITS-1:0] ram_wr_addr, ram_rd_addr;
    logic [WORD_BITS-1:0] ram_wr_data, ram_rd_data;
    logic                 valid_reg, first_reg, last_reg;
    logic [CHAN_BITS-1:0] out_chan_reg;
    logic [ADDR_BITS-1:0] out_tap_reg;
    logic [DATA_BITS-1:0] chan_words [CHANNELS];

    assign sweep_done  = (chan_reg == LAST_CHAN) && (tap_reg == LAST_TAP);
    assign ram_rd_addr = newest_ptr_reg - tap_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RESET_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
`ifdef TAP_DELAY_BUFFER_CLEAR_EN
            ST_CLEAR: if (clear_addr_reg == LAST_TAP) state_next = ST_IDLE;
`else
            ST_CLEAR: state_next = ST_IDLE;
`endif
            ST_IDLE:  if (accept) state_next = ST_SWEEP;
            ST_SWEEP: if (sweep_done) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // rst gates in_ready so a frame offered during reset is never taken.
    always_comb begin
        in_ready    = (state_reg == ST_IDLE) && !rst;
        accept      = in_valid && in_ready;
        issue       = (state_reg == ST_SWEEP);
        ram_wr_en   = accept;
        ram_wr_addr = wr_ptr_reg;
        ram_wr_data = in_data;
`ifdef TAP_DELAY_BUFFER_CLEAR_EN
        if (state_reg == ST_CLEAR) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = clear_addr_reg;
            ram_wr_data = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            newest_ptr_reg <= '0;
            tap_reg        <= '0;
            chan_reg       <= '0;
`ifdef TAP_DELAY_BUFFER_CLEAR_EN
            clear_addr_reg <= '0;
`endif
        end else begin
`ifdef TAP_DELAY_BUFFER_CLEAR_EN
            if (state_reg == ST_CLEAR) begin
                clear_addr_reg <= clear_addr_reg + ADDR_BITS'(1);
            end
`endif
            if (accept) begin
                newest_ptr_reg <= wr_ptr_reg;
                wr_ptr_reg     <= wr_ptr_reg + ADDR_BITS'(1);
                tap_reg        <= '0;
                chan_reg       <= '0;
            end else if (issue) begin
                tap_reg <= tap_reg + ADDR_BITS'(1);
                if (tap_reg == LAST_TAP) begin
                    chan_reg <= chan_reg + CHAN_BITS'(1);
                end
            end
        end
    end

    // Tags ride one stage behind the read issue to line up with the registered RAM output.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg    <= 1'b0;
            out_chan_reg <= '0;
            out_tap_reg  <= '0;
            first_reg    <= 1'b0;
            last_reg     <= 1'b0;
        end else begin
            valid_reg    <= issue;
            out_chan_reg <= issue ? chan_reg : '0;
            out_tap_reg  <= issue ? tap_reg : '0;
            first_reg    <= issue && (chan_reg == '0) && (tap_reg == '0);
            last_reg     <= issue && sweep_done;
        end
    end

    tap_delay_ram #(
        .WIDTH     (WORD_BITS),
        .DEPTH     (NUMBER_OF_TAPS),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_en   (issue),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan_slice
        assign chan_words[gi] = ram_rd_data[gi*DATA_BITS +: DATA_BITS];
    end

    // The RAM word has no reset, so data is forced to zero between beats.
    assign out_data  = valid_reg ? chan_words[out_chan_reg] : '0;
    assign out_valid = valid_reg;
    assign out_chan  = out_chan_reg;
    assign out_tap   = out_tap_reg;
    assign out_first = first_reg;
    assign out_last  = last_reg;

endmodule

// File: tb/tb_tap_delay_buffer.sv
// Directed bench for tap_delay_buffer with 8 taps x 2 channels.
// Expectations for unwritten taps follow TAP_DELAY_BUFFER_CLEAR_EN.
module tb_tap_delay_buffer;

    localparam int DB    = 16;
    localparam int C     = 2;
    localparam int N     = 8;
    localparam int AB    = 3;
    localparam int CB    = 1;
    localparam int BEATS = C * N;
`ifdef TAP_DELAY_BUFFER_CLEAR_EN
    localparam int CLEAR_CYCLES = N;
    localparam bit HAS_CLEAR    = 1'b1;
`else
    localparam int CLEAR_CYCLES = 0;
    localparam bit HAS_CLEAR    = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [C*DB-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DB-1:0] out_data;
    logic [CB-1:0] out_chan;
    logic [AB-1:0] out_tap;
    logic          out_first;
    logic          out_last;

    int n_checks = 0;
    int n_fails  = 0;

    logic          bv [BEATS];
    logic [DB-1:0] bd [BEATS];
    logic [CB-1:0] bc [BEATS];
    logic [AB-1:0] bt [BEATS];
    logic          bf [BEATS];
    logic          bl [BEATS];

    tap_delay_buffer #(
        .DATA_BITS      (DB),
        .CHANNELS       (C),
        .NUMBER_OF_TAPS (N),
        .ADDR_BITS      (AB),
        .CHAN_BITS      (CB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_tap   (out_tap),
        .out_first (out_first),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Offers a frame and returns one cycle after the accepting edge (issue cycle of tap 0).
    task automatic push_frame(input logic [C*DB-1:0] d, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic capture_sweep();
        for (int k = 0; k < BEATS; k++) begin
            step();
            bv[k] = out_valid;
            bd[k] = out_data;
            bc[k] = out_chan;
            bt[k] = out_tap;
            bf[k] = out_first;
            bl[k] = out_last;
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = '1;
        step();
        step();
        n_checks++;
        if ({in_ready, out_valid, out_data, out_chan, out_tap, out_first, out_last} !== '0) begin
            n_fails++;
            $display("FAIL reset_hold: rdy=%b vld=%b data=%h chan=%0d tap=%0d first=%b last=%b, expected all 0",
                     in_ready, out_valid, out_data, out_chan, out_tap, out_first, out_last);
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        for (int k = 0; k <= CLEAR_CYCLES; k++) begin
            n_checks++;
            if (in_ready !== (k == CLEAR_CYCLES)) begin
                n_fails++;
                $display("FAIL reset_release_ready: cycle %0d in_ready=%b expected %b",
                         k, in_ready, (k == CLEAR_CYCLES));
            end
            n_checks++;
            if ({out_valid, out_data, out_chan, out_tap, out_first, out_last} !== '0) begin
                n_fails++;
                $display("FAIL reset_release_outputs: cycle %0d vld=%b data=%h, expected 0", k, out_valid, out_data);
            end
            if (k != CLEAR_CYCLES) step();
        end
        $display("test_reset: released, idle after %0d cycles", CLEAR_CYCLES);
    endtask

    task automatic test_single_frame();
        bit ok;
        logic [DB-1:0] exp_d;
        push_frame({16'h0200, 16'h0100}, ok);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL single_accept: in_ready never rose, expected acceptance");
        end
        capture_sweep();
        for (int k = 0; k < BEATS; k++) begin
            n_checks++;
            if (bv[k] !== 1'b1 || bc[k] !== CB'(k / N) || bt[k] !== AB'(k % N) ||
                bf[k] !== (k == 0) || bl[k] !== (k == BEATS - 1)) begin
                n_fails++;
                $display("FAIL single_tags: beat %0d vld=%b chan=%0d tap=%0d first=%b last=%b, expected 1 %0d %0d %b %b",
                         k, bv[k], bc[k], bt[k], bf[k], bl[k], k / N, k % N, (k == 0), (k == BEATS - 1));
            end
            exp_d = (k % N != 0) ? 16'h0000 : ((k / N == 0) ? 16'h0100 : 16'h0200);
            if (HAS_CLEAR || (k % N == 0)) begin
                n_checks++;
                if (bd[k] !== exp_d) begin
                    n_fails++;
                    $display("FAIL single_data: beat %0d data=%h expected %h", k, bd[k], exp_d);
                end
            end
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL single_end: out_valid=%b after last beat, expected 0", out_valid);
        end
        $display("test_single_frame: sweep of 16 beats checked");
    endtask

    task automatic test_pointer_wrap();
        bit ok;
        logic [DB-1:0] exp_d;
        for (int v = 1; v <= 10; v++) begin
            push_frame({16'(-v), 16'(v)}, ok);
            n_checks++;
            if (!ok) begin
                n_fails++;
                $display("FAIL wrap_accept: frame %0d not accepted", v);
            end
            if (v == 10) capture_sweep();
        end
        for (int k = 0; k < BEATS; k++) begin
            exp_d = (k / N == 0) ? 16'(10 - k % N) : 16'(-(10 - k % N));
            n_checks++;
            if (bv[k] !== 1'b1 || bd[k] !== exp_d) begin
                n_fails++;
                $display("FAIL wrap_data: beat %0d vld=%b data=%h expected %h", k, bv[k], bd[k], exp_d);
            end
        end
        $display("test_pointer_wrap: 10 frames pushed, final sweep checked");
    endtask

    task automatic test_back_to_back();
        logic [DB-1:0] acc_q [$];
        int accepts = 0, firsts = 0, last_acc = -1;
        bit pend = 1'b0;
        in_valid = 1'b1;
        in_data  = {16'h2000, 16'h1000};
        for (int cyc = 0; cyc < 150; cyc++) begin
            if (pend) begin
                pend = 1'b0;
                if (accepts == 4) in_valid = 1'b0;
                else in_data = {16'(16'h2000 + accepts), 16'(16'h1000 + accepts)};
            end
            if (out_valid && out_first) begin
                n_checks++;
                if (firsts >= acc_q.size() || out_data !== acc_q[firsts]) begin
                    n_fails++;
                    $display("FAIL b2b_frame_order: sweep %0d tap0 data=%h, expected frame %0d", firsts, out_data, firsts);
                end
                firsts++;
            end
            if (in_valid && in_ready) begin
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc !== 17) begin
                        n_fails++;
                        $display("FAIL b2b_interval: accept spacing %0d cycles, expected 17", cyc - last_acc);
                    end
                end
                acc_q.push_back(in_data[DB-1:0]);
                last_acc = cyc;
                accepts++;
                pend = 1'b1;
            end
            if (accepts == 4 && firsts == 4) break;
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (accepts !== 4 || firsts !== 4) begin
            n_fails++;
            $display("FAIL b2b_count: accepts=%0d sweeps=%0d, expected 4 and 4", accepts, firsts);
        end
        repeat (20) step();
        $display("test_back_to_back: %0d frames accepted, %0d sweeps seen", accepts, firsts);
    endtask

    task automatic test_mid_sweep_reset();
        bit ok;
        logic [DB-1:0] exp_d;
        push_frame({16'h0055, 16'h0044}, ok);
        repeat (5) step();
        n_checks++;
        if (!ok || out_valid !== 1'b1 || out_tap !== AB'(4)) begin
            n_fails++;
            $display("FAIL midrst_pre: ok=%b vld=%b tap=%0d, expected 1 1 4", ok, out_valid, out_tap);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_first !== 1'b0 || out_last !== 1'b0) begin
            n_fails++;
            $display("FAIL midrst_valid: vld=%b first=%b last=%b after rst, expected 0", out_valid, out_first, out_last);
        end
        rst = 1'b0;
        push_frame({16'h0000, 16'h0007}, ok);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL midrst_accept: frame not accepted after reset");
        end
        capture_sweep();
        for (int k = 0; k < BEATS; k++) begin
            exp_d = (k == 0) ? 16'h0007 : 16'h0000;
            if (HAS_CLEAR || (k % N == 0)) begin
                n_checks++;
                if (bv[k] !== 1'b1 || bd[k] !== exp_d || bt[k] !== AB'(k % N)) begin
                    n_fails++;
                    $display("FAIL midrst_data: beat %0d vld=%b tap=%0d data=%h expected tap %0d data %h",
                             k, bv[k], bt[k], bd[k], k % N, exp_d);
                end
            end
        end
        $display("test_mid_sweep_reset: reset mid-sweep, fresh history checked");
    endtask

    task automatic test_extremes();
        bit ok;
        push_frame({16'h7FFF, 16'h8000}, ok);
        capture_sweep();
        n_checks++;
        if (!ok || bd[0] !== 16'h8000 || bd[N] !== 16'h7FFF) begin
            n_fails++;
            $display("FAIL extremes_tap0: ok=%b ch0=%h ch1=%h, expected 8000 7fff", ok, bd[0], bd[N]);
        end
        n_checks++;
        if (bd[1] !== 16'h0007 || bd[N+1] !== 16'h0000) begin
            n_fails++;
            $display("FAIL extremes_tap1: ch0=%h ch1=%h, expected 0007 0000", bd[1], bd[N+1]);
        end
        $display("test_extremes: full-scale samples read back");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_pointer_wrap();
        test_back_to_back();
        test_mid_sweep_reset();
        test_extremes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
